// File: rtl/vga_compositor_pkg.sv
// Shared types and constants for the scaled VGA compositor.
// Latency: n/a (types, constants and a combinational helper only).
// Backpressure: n/a.
//
// Contents:
//   PKG_COLOR_BITS / PKG_COORD_BITS - channel and coordinate widths the structs are built on
//   SYNC_POL_*                      - sync polarity encodings
//   rgb_t                           - {r,g,b} pixel
//   compositor_cfg_t                - per-frame shadowed configuration
//   blend_avg()                     - per-channel (a+b)>>1 average
package vga_compositor_pkg;

  // The packed structs below fix the channel and coordinate widths; the
  // compositor's COLOR_BITS/COORD_BITS parameters default to these values
  // and must be kept equal to them.
  localparam int PKG_COLOR_BITS = 6;
  localparam int PKG_COORD_BITS = 12;

  localparam logic SYNC_POL_ACTIVE_LOW  = 1'b0;
  localparam logic SYNC_POL_ACTIVE_HIGH = 1'b1;

  typedef struct packed {
    logic [PKG_COLOR_BITS-1:0] r;
    logic [PKG_COLOR_BITS-1:0] g;
    logic [PKG_COLOR_BITS-1:0] b;
  } rgb_t;

  typedef struct packed {
    logic [1:0]                scale_log2;
    logic [PKG_COORD_BITS-1:0] win_x;
    logic [PKG_COORD_BITS-1:0] win_y;
    rgb_t                      fg;
    rgb_t                      bg;
    logic                      blend;
  } compositor_cfg_t;

  // Average of two pixels; the sum is formed one bit wider so the carry
  // survives the shift, then truncated back to channel width.
  function automatic rgb_t blend_avg(input rgb_t a, input rgb_t b);
    rgb_t res;
    res.r = PKG_COLOR_BITS'(({1'b0, a.r} + {1'b0, b.r}) >> 1);
    res.g = PKG_COLOR_BITS'(({1'b0, a.g} + {1'b0, b.g}) >> 1);
    res.b = PKG_COLOR_BITS'(({1'b0, a.b} + {1'b0, b.b}) >> 1);
    return res;
  endfunction

endpackage

// File: rtl/vga_scaled_compositor_if.sv
// Framebuffer RAM read bus between the compositor and its pixel RAM.
// Latency: read data returns a fixed number of cycles after the address.
// Backpressure: none; the RAM must accept one read per cycle.
//
// Signals:
//   mem_read_en    - read strobe (master -> RAM)
//   mem_read_addr  - {row, col} read address (master -> RAM)
//   mem_read_data  - {R,G,B} pixel word (RAM -> master)
interface vga_scaled_compositor_if
  import vga_compositor_pkg::*;
#(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 3 * PKG_COLOR_BITS
);
  logic                  mem_read_en;
  logic [ADDR_WIDTH-1:0] mem_read_addr;
  logic [DATA_WIDTH-1:0] mem_read_data;

  modport master (output mem_read_en, output mem_read_addr, input mem_read_data);
  modport slave  (input mem_read_en, input mem_read_addr, output mem_read_data);
endinterface

// File: rtl/vga_delay_line.sv
// Fixed-depth register delay line used to keep side-band bits aligned with pixels.
// Latency: DEPTH cycles (DEPTH=0 is a combinational pass-through).
// Backpressure: none; shifts every cycle.
//
// Ports:
//   clk_pixel, reset - clock and synchronous active-high reset (stages load RST_VAL)
//   d_i              - WIDTH-bit input
//   q_o              - input delayed by DEPTH cycles
module vga_delay_line #(
  parameter int               WIDTH   = 1,
  parameter int               DEPTH   = 1,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk_pixel,
  input  logic             reset,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  if (DEPTH == 0) begin : g_pass
    logic unused_clk_rst;
    assign unused_clk_rst = clk_pixel ^ reset;
    assign q_o = d_i;
  end else begin : g_regs
    logic [WIDTH-1:0] stage_q [DEPTH];

    always_ff @(posedge clk_pixel) begin
      if (reset) begin
        for (int i = 0; i < DEPTH; i++) stage_q[i] <= RST_VAL;
      end else begin
        stage_q[0] <= d_i;
        for (int i = 1; i < DEPTH; i++) stage_q[i] <= stage_q[i-1];
      end
    end

    assign q_o = stage_q[DEPTH-1];
  end

endmodule

// File: rtl/vga_scaled_compositor.sv
// Per-pixel compositor: windowed 2^k-scaled framebuffer read, text overlay, background fill.
// Latency: in_* to vga_* is MEM_LATENCY+2 cycles; syncs and active share that delay.
// Backpressure: none; one pixel per clk_pixel, RAM must return data every cycle.
//
// Optional feature macro: VGA_COMPOSITOR_BLEND_EN adds cfg_blend (50/50 overlay
// blend inside the window); without it the overlay is always opaque.
//
// Ports:
//   clk_pixel, reset        - pixel clock, synchronous active-high reset
//   in_x/in_y/in_active     - coordinates and active flag from the timing controller
//   in_hsync/in_vsync       - syncs at pin polarity
//   overlay_bit             - text-layer pixel, OVL_LATENCY cycles after its coordinates
//   cfg_*                   - configuration, captured once per frame at the vsync edge
//   mem                     - framebuffer RAM read bus (master side)
//   vga_rgb/vga_*sync/vga_active - aligned pixel outputs
//   frame_count             - number of vsync leading edges seen since reset
module vga_scaled_compositor
  import vga_compositor_pkg::*;
#(
  parameter int COLOR_BITS        = PKG_COLOR_BITS,
  parameter int COORD_BITS        = PKG_COORD_BITS,
  parameter int IMG_W_BITS        = 8,
  parameter int IMG_HEIGHT        = 192,
  parameter int IMG_H_BITS        = 8,
  parameter int MEM_LATENCY       = 1,
  parameter int OVL_LATENCY       = 1,
  parameter int VSYNC_ACTIVE_HIGH = 0
) (
  input  logic                    clk_pixel,
  input  logic                    reset,
  input  logic [COORD_BITS-1:0]   in_x,
  input  logic [COORD_BITS-1:0]   in_y,
  input  logic                    in_active,
  input  logic                    in_hsync,
  input  logic                    in_vsync,
  input  logic                    overlay_bit,
  input  logic [1:0]              cfg_scale_log2,
  input  logic [COORD_BITS-1:0]   cfg_win_x,
  input  logic [COORD_BITS-1:0]   cfg_win_y,
  input  logic [3*COLOR_BITS-1:0] cfg_fg,
  input  logic [3*COLOR_BITS-1:0] cfg_bg,
`ifdef VGA_COMPOSITOR_BLEND_EN
  input  logic                    cfg_blend,
`endif
  vga_scaled_compositor_if.master mem,
  output logic [3*COLOR_BITS-1:0] vga_rgb,
  output logic                    vga_hsync,
  output logic                    vga_vsync,
  output logic                    vga_active,
  output logic [15:0]             frame_count
);

  localparam int   ADDR_WIDTH = IMG_W_BITS + IMG_H_BITS;
  localparam logic SYNC_ACT   = (VSYNC_ACTIVE_HIGH != 0) ? SYNC_POL_ACTIVE_HIGH : SYNC_POL_ACTIVE_LOW;
  localparam logic SYNC_IDLE  = !SYNC_ACT;
  // The overlay already lags by OVL_LATENCY; pad it to meet stage C.
  localparam int   OVL_DELAY  = MEM_LATENCY + 1 - OVL_LATENCY;
  localparam logic [COORD_BITS-1:0] IMG_W_LIM = COORD_BITS'(1 << IMG_W_BITS);
  localparam logic [COORD_BITS-1:0] IMG_H_LIM = COORD_BITS'(IMG_HEIGHT);

  // ---------------- Frame edge, shadow config, frame counter ----------------
  logic            vs_act, vs_act_q, frame_edge;
  compositor_cfg_t cfg_q, cfg_d;
  logic [15:0]     frame_count_q, frame_count_d;

  assign vs_act     = (in_vsync == SYNC_ACT);
  assign frame_edge = vs_act && !vs_act_q;

  always_comb begin
    cfg_d         = cfg_q;
    frame_count_d = frame_count_q;
    if (frame_edge) begin
      cfg_d.scale_log2 = cfg_scale_log2;
      cfg_d.win_x      = cfg_win_x;
      cfg_d.win_y      = cfg_win_y;
      cfg_d.fg         = rgb_t'(cfg_fg);
      cfg_d.bg         = rgb_t'(cfg_bg);
`ifdef VGA_COMPOSITOR_BLEND_EN
      cfg_d.blend      = cfg_blend;
`else
      cfg_d.blend      = 1'b0;
`endif
      frame_count_d    = frame_count_q + 16'd1;
    end
  end

  // vs_act_q clears to "inactive" so a vsync already asserted when reset
  // releases still counts as the first edge and loads the config.
  always_ff @(posedge clk_pixel) begin
    if (reset) begin
      vs_act_q      <= 1'b0;
      cfg_q         <= '0;
      frame_count_q <= '0;
    end else begin
      vs_act_q      <= vs_act;
      cfg_q         <= cfg_d;
      frame_count_q <= frame_count_d;
    end
  end

  assign frame_count = frame_count_q;

  // ---------------- Stage A: window test and address ----------------
  // One extra bit holds the sign so left/above-window pixels are rejected.
  logic [COORD_BITS:0]   dx, dy;
  logic [COORD_BITS-1:0] dx_s, dy_s;
  logic                  in_win_d;
  logic [ADDR_WIDTH-1:0] addr_d, addr_q;
  logic                  in_win_a_q, active_a_q, hsync_a_q, vsync_a_q;

  always_comb begin
    dx       = {1'b0, in_x} - {1'b0, cfg_q.win_x};
    dy       = {1'b0, in_y} - {1'b0, cfg_q.win_y};
    dx_s     = dx[COORD_BITS-1:0] >> cfg_q.scale_log2;
    dy_s     = dy[COORD_BITS-1:0] >> cfg_q.scale_log2;
    in_win_d = in_active && !dx[COORD_BITS] && !dy[COORD_BITS]
               && (dx_s < IMG_W_LIM) && (dy_s < IMG_H_LIM);
    // Address is held outside the window so the RAM bus stays quiet.
    addr_d   = in_win_d ? {dy_s[IMG_H_BITS-1:0], dx_s[IMG_W_BITS-1:0]} : addr_q;
  end

  always_ff @(posedge clk_pixel) begin
    if (reset) begin
      in_win_a_q <= 1'b0;
      active_a_q <= 1'b0;
      hsync_a_q  <= SYNC_IDLE;
      vsync_a_q  <= SYNC_IDLE;
      addr_q     <= '0;
    end else begin
      in_win_a_q <= in_win_d;
      active_a_q <= in_active;
      hsync_a_q  <= in_hsync;
      vsync_a_q  <= in_vsync;
      addr_q     <= addr_d;
    end
  end

  assign mem.mem_read_en   = in_win_a_q;
  assign mem.mem_read_addr = addr_q;

  // ---------------- Stage B: match RAM latency ----------------
  logic [3:0] stage_b;
  logic       in_win_b, active_b, hsync_b, vsync_b, ovl_c;

  vga_delay_line #(
    .WIDTH   (4),
    .DEPTH   (MEM_LATENCY),
    .RST_VAL ({1'b0, 1'b0, SYNC_IDLE, SYNC_IDLE})
  ) u_align_b (
    .clk_pixel (clk_pixel),
    .reset     (reset),
    .d_i       ({in_win_a_q, active_a_q, hsync_a_q, vsync_a_q}),
    .q_o       (stage_b)
  );

  assign {in_win_b, active_b, hsync_b, vsync_b} = stage_b;

  vga_delay_line #(
    .WIDTH   (1),
    .DEPTH   (OVL_DELAY),
    .RST_VAL (1'b0)
  ) u_align_ovl (
    .clk_pixel (clk_pixel),
    .reset     (reset),
    .d_i       (overlay_bit),
    .q_o       (ovl_c)
  );

  // ---------------- Stage C: mix and output register ----------------
  rgb_t img, pix_d, rgb_q;
  logic active_q, hsync_q, vsync_q;

  assign img = rgb_t'(mem.mem_read_data);

  always_comb begin
    pix_d = '0;
    if (!active_b) begin
      pix_d = '0;
    end else if (ovl_c) begin
`ifdef VGA_COMPOSITOR_BLEND_EN
      if (cfg_q.blend && in_win_b) pix_d = blend_avg(cfg_q.fg, img);
      else                         pix_d = cfg_q.fg;
`else
      pix_d = cfg_q.fg;
`endif
    end else if (in_win_b) begin
      pix_d = img;
    end else begin
      pix_d = cfg_q.bg;
    end
  end

  always_ff @(posedge clk_pixel) begin
    if (reset) begin
      rgb_q    <= '0;
      active_q <= 1'b0;
      hsync_q  <= SYNC_IDLE;
      vsync_q  <= SYNC_IDLE;
    end else begin
      rgb_q    <= pix_d;
      active_q <= active_b;
      hsync_q  <= hsync_b;
      vsync_q  <= vsync_b;
    end
  end

  assign vga_rgb    = rgb_q;
  assign vga_active = active_q;
  assign vga_hsync  = hsync_q;
  assign vga_vsync  = vsync_q;

endmodule

// File: tb/tb_vga_scaled_compositor.sv
// Directed bench for vga_scaled_compositor with a RAM whose contents equal the address.
// Latency: outputs checked MEM_LATENCY+2 = 3 cycles after inputs are applied.
// Backpressure: n/a.
module tb_vga_scaled_compositor;

  logic        clk_pixel = 1'b0;
  logic        reset;
  logic [11:0] in_x, in_y;
  logic        in_active, in_hsync, in_vsync, overlay_bit;
  logic [1:0]  cfg_scale_log2;
  logic [11:0] cfg_win_x, cfg_win_y;
  logic [17:0] cfg_fg, cfg_bg;
`ifdef VGA_COMPOSITOR_BLEND_EN
  logic        cfg_blend;
`endif
  logic [17:0] vga_rgb;
  logic        vga_hsync, vga_vsync, vga_active;
  logic [15:0] frame_count;

  int checks   = 0;
  int failures = 0;

  vga_scaled_compositor_if #(.ADDR_WIDTH(16), .DATA_WIDTH(18)) mem_bus ();

  vga_scaled_compositor #(
    .COLOR_BITS(6), .COORD_BITS(12), .IMG_W_BITS(8), .IMG_HEIGHT(192),
    .IMG_H_BITS(8), .MEM_LATENCY(1), .OVL_LATENCY(1), .VSYNC_ACTIVE_HIGH(0)
  ) dut (
    .clk_pixel      (clk_pixel),
    .reset          (reset),
    .in_x           (in_x),
    .in_y           (in_y),
    .in_active      (in_active),
    .in_hsync       (in_hsync),
    .in_vsync       (in_vsync),
    .overlay_bit    (overlay_bit),
    .cfg_scale_log2 (cfg_scale_log2),
    .cfg_win_x      (cfg_win_x),
    .cfg_win_y      (cfg_win_y),
    .cfg_fg         (cfg_fg),
    .cfg_bg         (cfg_bg),
`ifdef VGA_COMPOSITOR_BLEND_EN
    .cfg_blend      (cfg_blend),
`endif
    .mem            (mem_bus.master),
    .vga_rgb        (vga_rgb),
    .vga_hsync      (vga_hsync),
    .vga_vsync      (vga_vsync),
    .vga_active     (vga_active),
    .frame_count    (frame_count)
  );

  always #5 clk_pixel = ~clk_pixel;

  // One-cycle RAM; each word holds its own address.
  always @(posedge clk_pixel) begin
    if (reset) mem_bus.mem_read_data <= '0;
    else if (mem_bus.mem_read_en) mem_bus.mem_read_data <= {2'b00, mem_bus.mem_read_addr};
  end

  task automatic tick();
    @(posedge clk_pixel);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  // Vsync pulse (active low) giving one frame edge.
  task automatic frame_edge();
    in_vsync = 1'b0;
    tick();
    tick();
    in_vsync = 1'b1;
    tick();
  endtask

  // Hold one pixel: check the RAM request after 1 cycle, the output after 3.
  task automatic px(input string tag, input int x, input int y, input logic act,
                    input logic ovl, input logic exp_en, input logic [15:0] exp_addr,
                    input logic [17:0] exp_rgb);
    in_x        = 12'(x);
    in_y        = 12'(y);
    in_active   = act;
    overlay_bit = ovl;
    tick();
    chk({tag, ".en"},   32'(mem_bus.mem_read_en),   32'(exp_en));
    chk({tag, ".addr"}, 32'(mem_bus.mem_read_addr), 32'(exp_addr));
    tick();
    tick();
    chk({tag, ".rgb"},  32'(vga_rgb),    32'(exp_rgb));
    chk({tag, ".act"},  32'(vga_active), 32'(act));
  endtask

  initial begin
    reset = 1'b1;
    in_x = '0; in_y = '0; in_active = 1'b0; in_hsync = 1'b1; in_vsync = 1'b1;
    overlay_bit = 1'b0;
    cfg_scale_log2 = 2'd2; cfg_win_x = '0; cfg_win_y = '0;
    cfg_fg = 18'h3FFFF; cfg_bg = 18'h15555;
`ifdef VGA_COMPOSITOR_BLEND_EN
    cfg_blend = 1'b0;
`endif
    tick();
    tick();
    chk("rst.rgb",   32'(vga_rgb),               32'h0);
    chk("rst.act",   32'(vga_active),            32'h0);
    chk("rst.hs",    32'(vga_hsync),             32'h1);
    chk("rst.vs",    32'(vga_vsync),             32'h1);
    chk("rst.en",    32'(mem_bus.mem_read_en),   32'h0);
    chk("rst.addr",  32'(mem_bus.mem_read_addr), 32'h0);
    chk("rst.fc",    32'(frame_count),           32'h0);
    reset = 1'b0;

    // Frame 1: scale 4, window at origin.
    frame_edge();
    chk("fc1", 32'(frame_count), 32'd1);
    px("s4_13_9",   13,   9, 1'b1, 1'b0, 1'b1, 16'h0203, 18'h00203);
    px("s4_13_767", 13, 767, 1'b1, 1'b0, 1'b1, 16'hBF03, 18'h0BF03);
    px("s4_13_768", 13, 768, 1'b1, 1'b0, 1'b0, 16'hBF03, 18'h15555);

    // hsync must appear exactly 3 cycles later.
    in_hsync = 1'b0;
    tick();
    tick();
    chk("hs_d2", 32'(vga_hsync), 32'h1);
    tick();
    chk("hs_d3", 32'(vga_hsync), 32'h0);
    in_hsync = 1'b1;
    tick(); tick(); tick();

    // Frame 2: scale 1, window at (100,50).
    cfg_scale_log2 = 2'd0; cfg_win_x = 12'd100; cfg_win_y = 12'd50;
    frame_edge();
    chk("fc2", 32'(frame_count), 32'd2);
    px("w_99_50",   99,  50, 1'b1, 1'b0, 1'b0, 16'hBF03, 18'h15555);
    px("w_100_50", 100,  50, 1'b1, 1'b0, 1'b1, 16'h0000, 18'h00000);
    px("w_355_50", 355,  50, 1'b1, 1'b0, 1'b1, 16'h00FF, 18'h000FF);
    px("w_356_50", 356,  50, 1'b1, 1'b0, 1'b0, 16'h00FF, 18'h15555);
    px("w_100_49", 100,  49, 1'b1, 1'b0, 1'b0, 16'h00FF, 18'h15555);
    px("w_100_241",100, 241, 1'b1, 1'b0, 1'b1, 16'hBF00, 18'h0BF00);
    px("w_100_242",100, 242, 1'b1, 1'b0, 1'b0, 16'hBF00, 18'h15555);

    // Overlay: fg inside and outside the window, black in blanking.
    px("ovl_in",    100, 50, 1'b1, 1'b1, 1'b1, 16'h0000, 18'h3FFFF);
    px("ovl_out",    99, 50, 1'b1, 1'b1, 1'b0, 16'h0000, 18'h3FFFF);
    px("ovl_blank", 100, 50, 1'b0, 1'b1, 1'b0, 16'h0000, 18'h00000);

    // Streaming pixels with the overlay arriving one cycle after its coordinates.
    in_y = 12'd60; in_active = 1'b1;
    in_x = 12'd100; overlay_bit = 1'b0; tick();
    in_x = 12'd101; overlay_bit = 1'b0; tick();
    in_x = 12'd102; overlay_bit = 1'b1; tick();
    chk("stream100", 32'(vga_rgb), 32'h00A00);
    in_x = 12'd103; overlay_bit = 1'b0; tick();
    chk("stream101", 32'(vga_rgb), 32'h3FFFF);
    overlay_bit = 1'b0; tick();
    chk("stream102", 32'(vga_rgb), 32'h00A02);
    tick();
    chk("stream103", 32'(vga_rgb), 32'h00A03);

    // Mid-frame scale change is ignored until the next vsync edge.
    cfg_scale_log2 = 2'd3;
    px("mid_chg", 110, 100, 1'b1, 1'b0, 1'b1, 16'h320A, 18'h0320A);
    chk("fc_mid", 32'(frame_count), 32'd2);
    frame_edge();
    chk("fc3", 32'(frame_count), 32'd3);
    px("new_scale", 110, 100, 1'b1, 1'b0, 1'b1, 16'h0601, 18'h00601);

    // One-cycle reset in the middle of a line.
    in_hsync = 1'b0;
    tick(); tick(); tick();
    chk("pre_rst.rgb", 32'(vga_rgb),   32'h00601);
    chk("pre_rst.hs",  32'(vga_hsync), 32'h0);
    reset = 1'b1;
    tick();
    chk("mrst.rgb",  32'(vga_rgb),               32'h0);
    chk("mrst.hs",   32'(vga_hsync),             32'h1);
    chk("mrst.vs",   32'(vga_vsync),             32'h1);
    chk("mrst.act",  32'(vga_active),            32'h0);
    chk("mrst.fc",   32'(frame_count),           32'h0);
    chk("mrst.en",   32'(mem_bus.mem_read_en),   32'h0);
    chk("mrst.addr", 32'(mem_bus.mem_read_addr), 32'h0);
    reset = 1'b0;
    // Shadow config is now cleared: scale 1, window at origin.
    tick();
    chk("post_rst.en",   32'(mem_bus.mem_read_en),   32'h1);
    chk("post_rst.addr", 32'(mem_bus.mem_read_addr), 32'h646E);
    tick();
    chk("post_rst.act2", 32'(vga_active), 32'h0);
    tick();
    chk("post_rst.act3", 32'(vga_active), 32'h1);
    chk("post_rst.rgb",  32'(vga_rgb),    32'h0646E);
    chk("post_rst.hs",   32'(vga_hsync),  32'h0);
    in_hsync = 1'b1;
    frame_edge();
    chk("fc_after_rst", 32'(frame_count), 32'd1);

`ifdef VGA_COMPOSITOR_BLEND_EN
    cfg_scale_log2 = 2'd0; cfg_win_x = '0; cfg_win_y = '0;
    cfg_fg = 18'h3F000; cfg_blend = 1'b1;
    frame_edge();
    px("blend_in",  40,  21, 1'b1, 1'b1, 1'b1, 16'h1528, {6'd32, 6'd10, 6'd20});
    px("blend_out", 40, 300, 1'b1, 1'b1, 1'b0, 16'h1528, 18'h3F000);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
